// File: rtl/membus_bridge_pkg.sv
// Shared definitions for the membus_bridge block: bus widths, backing store size
// and the sequencing state type.
package membus_bridge_pkg;

    localparam int unsigned ADDR_W    = 17;
    localparam int unsigned MEM_BYTES = 65536;

    typedef enum logic [2:0] {
        StIdle,
        StAcc0,
        StAcc1,
        StCap,
        StResp
    } state_e;

endpackage

// File: rtl/membus_bridge_if.sv
// CPU-side request/response channel of membus_bridge.
//   req_*  : request (valid/ready) carrying write flag, halfword flag, address, data
//   rsp_*  : response (valid/ready) carrying read data and range-error flag
// master modport = CPU / request producer, slave modport = bridge.
interface membus_bridge_if;
    import membus_bridge_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_half;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_half, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_half, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/membus_bridge.sv
// membus_bridge: turns byte/halfword CPU requests into single-byte strobes for a
// memory controller with 1-cycle synchronous read, range-checks addresses and
// returns little-endian read data. One request in flight.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus             request/response channel (slave side)
//   mem_addr_o      byte address to memctl
//   mem_wdata_o     byte write data to memctl
//   mem_write_en_o  write strobe
//   mem_read_en_o   read strobe
//   mem_rdata_i     read data, valid the cycle after mem_read_en_o
module membus_bridge
    import membus_bridge_pkg::*;
#(
    parameter int unsigned MemBytes = MEM_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    membus_bridge_if.slave    bus,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              mem_write_en_o,
    output logic              mem_read_en_o,
    input  logic [7:0]        mem_rdata_i
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic              write_q;
    logic              half_q;

    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [15:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              mem_we_q;
    logic              mem_re_q;

    logic              range_err;
    logic              accept;

    // A halfword at the last byte would need addr+1 beyond the store, so it is
    // rejected too; this guarantees addr+1 never wraps.
    always_comb begin
        range_err = (32'(bus.req_addr) >= MemBytes) ||
                    (bus.req_half && (32'(bus.req_addr) == MemBytes - 1));
    end

    assign accept = bus.req_valid && req_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            half_q      <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Ready rises on the first edge after reset release.
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        write_q     <= bus.req_write;
                        half_q      <= bus.req_half;
                        req_ready_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        if (range_err) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q     <= StAcc0;
                            rsp_err_q   <= 1'b0;
                            mem_addr_q  <= bus.req_addr;
                            mem_wdata_q <= bus.req_wdata[7:0];
                            mem_we_q    <= bus.req_write;
                            mem_re_q    <= !bus.req_write;
                        end
                    end
                end
                StAcc0: begin
                    if (half_q) begin
                        // Keep the same strobe type, move to the upper byte.
                        state_q     <= StAcc1;
                        mem_addr_q  <= addr_q + ADDR_W'(1);
                        mem_wdata_q <= wdata_q[15:8];
                    end else begin
                        mem_we_q <= 1'b0;
                        mem_re_q <= 1'b0;
                        if (write_q) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= StCap;
                        end
                    end
                end
                StAcc1: begin
                    mem_we_q <= 1'b0;
                    mem_re_q <= 1'b0;
                    if (write_q) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        // Data for the byte0 read issued in StAcc0.
                        rsp_rdata_q[7:0] <= mem_rdata_i;
                        state_q          <= StCap;
                    end
                end
                StCap: begin
                    if (half_q) begin
                        rsp_rdata_q[15:8] <= mem_rdata_i;
                    end else begin
                        rsp_rdata_q[7:0] <= mem_rdata_i;
                    end
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    rsp_valid_q <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_re_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign mem_write_en_o = mem_we_q;
    assign mem_read_en_o  = mem_re_q;

endmodule

// File: tb/tb_membus_bridge.sv
// Self-checking bench for membus_bridge: a byte-array memory with 1-cycle
// synchronous read stands in for memctl; a separate reference byte array plus
// latency/strobe rules predicts every response.
module tb_membus_bridge;
    import membus_bridge_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    membus_bridge_if bus ();

    membus_bridge #(.MemBytes(MEM_BYTES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_write_en_o (mem_we),
        .mem_read_en_o  (mem_re),
        .mem_rdata_i    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int strobe_cnt = 0;
    int accept_cnt = 0;

    // Memory model standing in for memctl.
    logic [7:0] mem [0:MEM_BYTES-1];
    logic       mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 8));
            mem_init_done = 1'b1;
        end
        if (mem_re && mem_addr < ADDR_W'(MEM_BYTES)) mem_rdata <= mem[mem_addr[15:0]];
        if (mem_we && mem_addr < ADDR_W'(MEM_BYTES)) mem[mem_addr[15:0]] = mem_wdata;
    end

    always @(posedge clk) begin
        if (rst_n && (mem_we || mem_re)) strobe_cnt++;
        if (rst_n && bus.req_valid && bus.req_ready) accept_cnt++;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(mem_we && mem_re)) else begin
                n_errors++;
                $error("FAIL both_strobes: write_en=%0b read_en=%0b required not both 1",
                       mem_we, mem_re);
            end
        end
    end

    logic [7:0] ref_mem [0:MEM_BYTES-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request (caller is at a negedge), wait for the response, hold it
    // for 'delay' cycles with rsp_ready low, then complete the handshake.
    task automatic do_req(input logic w, input logic h, input logic [ADDR_W-1:0] a,
                          input logic [15:0] d, input int delay, input logic hold);
        int         lat;
        int         exp_lat;
        int         n;
        int         s0;
        int         acc0;
        int         ia;
        logic       err;
        logic [15:0] exp_rd;
        ia      = int'(a);
        err     = (ia >= int'(MEM_BYTES)) || (h && ia == int'(MEM_BYTES) - 1);
        exp_lat = err ? 1 : (w ? (h ? 3 : 2) : (h ? 4 : 3));
        exp_rd  = '0;
        if (!err && !w) exp_rd = h ? {ref_mem[ia + 1], ref_mem[ia]} : {8'h00, ref_mem[ia]};

        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_half  = h;
        bus.req_addr  = a;
        bus.req_wdata = d;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
        s0   = strobe_cnt;
        acc0 = accept_cnt;
        lat  = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && !hold) bus.req_valid = 1'b0;
        end while (!bus.rsp_valid && lat < 10);
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
        check("rsp_err", 32'(bus.rsp_err), 32'(err));
        check("strobe_count", 32'(strobe_cnt - s0), err ? 32'd0 : (h ? 32'd2 : 32'd1));
        if (!err && w) begin
            ref_mem[ia] = d[7:0];
            if (h) ref_mem[ia + 1] = d[15:8];
        end
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
        check("req_ready_after_hs", 32'(bus.req_ready), 32'd1);
        check("single_accept", 32'(accept_cnt - acc0), 32'd1);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'((i * 37 + 11) ^ (i >> 8));
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_half  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("reset_strobes", 32'({mem_we, mem_re}), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(bus.req_ready), 32'd1);

        // Byte write then read back.
        do_req(1'b1, 1'b0, 17'h00010, 16'h00A5, 0, 1'b0);
        do_req(1'b0, 1'b0, 17'h00010, 16'h0000, 0, 1'b0);

        // Halfword at the top of memory, read back as bytes and halfword.
        do_req(1'b1, 1'b1, 17'h0FFFE, 16'hBEEF, 0, 1'b0);
        do_req(1'b0, 1'b0, 17'h0FFFE, 16'h0000, 0, 1'b0);
        do_req(1'b0, 1'b0, 17'h0FFFF, 16'h0000, 0, 1'b0);
        do_req(1'b0, 1'b1, 17'h0FFFE, 16'h0000, 0, 1'b0);

        // Range errors, then contents unchanged.
        do_req(1'b0, 1'b1, 17'h0FFFF, 16'h0000, 0, 1'b0);
        do_req(1'b1, 1'b0, 17'h10000, 16'h0055, 0, 1'b0);
        do_req(1'b1, 1'b1, 17'h1FFFF, 16'h1234, 0, 1'b0);
        do_req(1'b0, 1'b1, 17'h0FFFE, 16'h0000, 0, 1'b0);

        // Stalled response with a new request already pending.
        do_req(1'b0, 1'b0, 17'h00010, 16'h0000, 5, 1'b1);

        // Reset while the second byte of a halfword write is on the bus.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_half  = 1'b1;
        bus.req_addr  = 17'h00200;
        bus.req_wdata = 16'h1234;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("acc1_write_en", 32'(mem_we), 32'd1);
        check("acc1_mem_addr", 32'(mem_addr), 32'h201);
        check("acc1_mem_wdata", 32'(mem_wdata), 32'h12);
        rst_n = 1'b0;
        #1;
        check("midop_strobes", 32'({mem_we, mem_re}), 32'd0);
        check("midop_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midop_req_ready", 32'(bus.req_ready), 32'd0);
        ref_mem[32'h200] = 8'h34;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_midop", 32'(bus.req_ready), 32'd1);
        check("no_rsp_after_midop", 32'(bus.rsp_valid), 32'd0);
        do_req(1'b0, 1'b1, 17'h00200, 16'h0000, 0, 1'b0);

        // Randomized traffic, back-to-back with req_valid held high.
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 7) == 0) ra = ADDR_W'(32'hFFFE + $urandom_range(0, 3));
            else ra = ADDR_W'($urandom_range(0, 63));
            do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                   16'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
